dmem_responder: RTL and testbench

//  Data-memory responder on the far end of the core's dmem interface (mem_enable/store_enable/

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: default geometry, debug FSM
// states and the address range test used by both the core and debug paths.
package dmem_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH_LOG2 = 8;
    localparam int CNT_WIDTH      = 32;

    typedef enum logic [1:0] {
        DBG_IDLE,
        DBG_DO,
        DBG_ACK
    } dbg_state_e;

    // A word address is backed by the array only if every bit above the index is zero.
    function automatic logic in_range(input logic [DEF_ADDR_WIDTH-1:0] addr,
                                      input int unsigned depth_log2);
        return (addr >> depth_log2) == '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM: one write or one read per cycle, registered read data.
// Storage is deliberately left without a reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[idx];
    end

    // NOTE: the storage array has no reset branch so it maps onto RAM macros;
    // contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Far-end responder for the core dmem port with a lower-priority debug port sharing
// one single-port array; loads have one cycle of latency and out-of-range hits are flagged.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_enable,
    input  logic                  store_enable,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [DATA_WIDTH-1:0] dmem_dataIn,
    output logic [DATA_WIDTH-1:0] dmem_dataOut,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ack,
    output logic                  err_oob,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    dbg_state_e state_q, state_d;

    logic core_in, dbg_in, core_ld, core_st, dbg_go;

    logic                  ram_we, ram_re;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    logic                  dout_sel_q, dout_sel_d;
    logic [DATA_WIDTH-1:0] dout_hold_q, dout_hold_d;
    logic                  dbg_sel_q, dbg_sel_d;
    logic [DATA_WIDTH-1:0] dbg_hold_q, dbg_hold_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;

    assign core_in = in_range(dmem_address, DEPTH_LOG2);
    assign dbg_in  = in_range(dbg_addr, DEPTH_LOG2);
    assign core_ld = mem_enable && !store_enable;
    assign core_st = mem_enable && store_enable;
    // The debug access only happens in a cycle the core leaves the array free.
    assign dbg_go  = (state_q == DBG_DO) && !mem_enable;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DBG_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DBG_IDLE: if (dbg_req && !mem_enable) state_d = DBG_DO;
            DBG_DO:   if (!mem_enable) state_d = DBG_ACK;
            DBG_ACK:  state_d = DBG_IDLE;
            default:  state_d = DBG_IDLE;
        endcase
    end

    always_comb begin
        dbg_ack = (state_q == DBG_ACK);
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_idx   = dmem_address[DEPTH_LOG2-1:0];
        ram_wdata = dmem_dataIn;
        if (mem_enable) begin
            ram_we = core_in && store_enable;
            ram_re = core_in && !store_enable;
        end else if (dbg_go) begin
            ram_idx   = dbg_addr[DEPTH_LOG2-1:0];
            ram_wdata = dbg_wdata;
            ram_we    = dbg_in && dbg_we;
            ram_re    = dbg_in && !dbg_we;
        end
    end

    dmem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (ram_idx),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Each read port shows fresh RAM data the cycle after its own read and a held copy
    // otherwise, so the other requester's reads never disturb it.
    always_comb begin
        dmem_dataOut = dout_sel_q ? ram_rdata : dout_hold_q;
        dbg_rdata    = dbg_sel_q ? ram_rdata : dbg_hold_q;

        dout_sel_d  = core_ld && core_in;
        dout_hold_d = (core_ld && !core_in) ? '0 : dmem_dataOut;
        dbg_sel_d   = dbg_go && !dbg_we && dbg_in;
        dbg_hold_d  = (dbg_go && !dbg_we && !dbg_in) ? '0 : dbg_rdata;

        err_d = err_q || (mem_enable && !core_in) || (dbg_go && !dbg_in);

        rd_count_d = rd_count_q;
        if (core_ld && (rd_count_q != '1)) rd_count_d = rd_count_q + 32'd1;
        wr_count_d = wr_count_q;
        if (core_st && (wr_count_q != '1)) wr_count_d = wr_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_sel_q  <= 1'b0;
            dout_hold_q <= '0;
            dbg_sel_q   <= 1'b0;
            dbg_hold_q  <= '0;
            err_q       <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            dout_sel_q  <= dout_sel_d;
            dout_hold_q <= dout_hold_d;
            dbg_sel_q   <= dbg_sel_d;
            dbg_hold_q  <= dbg_hold_d;
            err_q       <= err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign err_oob  = err_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal expectations
// plus randomized core/debug traffic compared every cycle against a behavioural model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enable = 1'b0;
    logic        store_enable = 1'b0;
    logic [31:0] dmem_address = '0;
    logic [63:0] dmem_dataIn = '0;
    logic [63:0] dmem_dataOut;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic [63:0] dbg_wdata = '0;
    logic [63:0] dbg_rdata;
    logic        dbg_ack;
    logic        err_oob;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    dmem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .mem_enable  (mem_enable),
        .store_enable(store_enable),
        .dmem_address(dmem_address),
        .dmem_dataIn (dmem_dataIn),
        .dmem_dataOut(dmem_dataOut),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata),
        .dbg_ack     (dbg_ack),
        .err_oob     (err_oob),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents and the visible outputs after each edge.
    logic [63:0] mem_m [256];
    logic [63:0] m_dout, m_drd;
    logic        m_err;
    logic [31:0] m_rd, m_wr;
    int          m_ph;      // 0 waiting for request, 1 granted, 2 acknowledging
    bit          model_live = 1'b0;

    task automatic model_reset();
        m_dout = '0;
        m_drd  = '0;
        m_err  = 1'b0;
        m_rd   = '0;
        m_wr   = '0;
        m_ph   = 0;
    endtask

    task automatic model_step();
        bit c_in, d_in;
        c_in = dmem_address < 32'd256;
        d_in = dbg_addr < 32'd256;
        if (mem_enable) begin
            if (!c_in) m_err = 1'b1;
            if (store_enable) begin
                if (c_in) mem_m[dmem_address[7:0]] = dmem_dataIn;
                if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 32'd1;
            end else begin
                m_dout = c_in ? mem_m[dmem_address[7:0]] : 64'd0;
                if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 32'd1;
            end
        end
        case (m_ph)
            0: if (dbg_req && !mem_enable) m_ph = 1;
            1: if (!mem_enable) begin
                if (dbg_we) begin
                    if (d_in) mem_m[dbg_addr[7:0]] = dbg_wdata;
                end else begin
                    m_drd = d_in ? mem_m[dbg_addr[7:0]] : 64'd0;
                end
                if (!d_in) m_err = 1'b1;
                m_ph = 2;
            end
            default: m_ph = 0;
        endcase
    endtask

    // One clock: model follows the edge, inputs may change 1ns later.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_live && rst) begin
                check("dout", dmem_dataOut, m_dout);
                check("dbg_rdata", dbg_rdata, m_drd);
                check("dbg_ack", 64'(dbg_ack), 64'(m_ph == 2));
                check("err_oob", 64'(err_oob), 64'(m_err));
                check("rd_count", 64'(rd_count), 64'(m_rd));
                check("wr_count", 64'(wr_count), 64'(m_wr));
            end
        end
    end

    task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [63:0] data);
        int waited;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = data;
        waited    = 0;
        do begin
            cycle();
            waited++;
        end while (m_ph != 2 && waited < 20);
        if (m_ph != 2) begin
            n_checks++;
            n_errors++;
            $display("FAIL dbg_op_timeout: no ack for addr %h after %0d cycles", addr, waited);
        end
        dbg_req = 1'b0;
        cycle();
    endtask

    initial begin
        int dbg_wait;
        bit dbg_busy;

        // Initial reset: everything reads zero while rst is low.
        repeat (2) cycle();
        check("rst_dout", dmem_dataOut, 64'd0);
        check("rst_dbg_rdata", dbg_rdata, 64'd0);
        check("rst_ack_err", {62'd0, dbg_ack, err_oob}, 64'd0);
        check("rst_counts", {rd_count, wr_count}, 64'd0);
        rst = 1'b1;
        model_reset();
        model_live = 1'b1;

        // Preload every location through the debug port so later loads are defined.
        for (int i = 0; i < 256; i++)
            dbg_op(1'b1, 32'(i), {32'hC0DE_0000 | 32'(i), 32'h1234_0000 ^ 32'(i)});
        check("preload_counts", {rd_count, wr_count}, 64'd0);

        // Store then load the same address on the next cycle.
        mem_enable = 1'b1; store_enable = 1'b1; dmem_address = 32'd5;
        dmem_dataIn = 64'hDEAD_BEEF_0123_4567;
        cycle();
        store_enable = 1'b0;
        cycle();
        mem_enable = 1'b0;
        check("t2_load5", dmem_dataOut, 64'hDEAD_BEEF_0123_4567);
        check("t2_wr", 64'(wr_count), 64'd1);
        check("t2_rd", 64'(rd_count), 64'd1);
        cycle();
        check("t2_hold", dmem_dataOut, 64'hDEAD_BEEF_0123_4567);

        // Out-of-range accesses.
        mem_enable = 1'b1; store_enable = 1'b0; dmem_address = 32'h0000_0100;
        cycle();
        check("t3_oob_load", dmem_dataOut, 64'd0);
        check("t3_err", 64'(err_oob), 64'd1);
        store_enable = 1'b1; dmem_dataIn = 64'hFFFF_0000_FFFF_0000;
        cycle();
        store_enable = 1'b0; dmem_address = 32'd0;
        cycle();
        mem_enable = 1'b0;
        check("t3_arr0", dmem_dataOut, 64'hC0DE_0000_1234_0000);
        check("t3_err_sticky", 64'(err_oob), 64'd1);

        // Debug write with the core idle: ack two cycles after the request.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd7; dbg_wdata = 64'hA5A5;
        cycle();
        check("t4_ack_c1", 64'(dbg_ack), 64'd0);
        cycle();
        check("t4_ack_c2", 64'(dbg_ack), 64'd1);
        dbg_req = 1'b0;
        cycle();
        check("t4_ack_drop", 64'(dbg_ack), 64'd0);
        mem_enable = 1'b1; store_enable = 1'b0; dmem_address = 32'd7;
        cycle();
        mem_enable = 1'b0;
        check("t4_load7", dmem_dataOut, 64'hA5A5);

        // Debug read held off by three core loads.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd7;
        mem_enable = 1'b1; store_enable = 1'b0; dmem_address = 32'd5;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t5_no_ack", 64'(dbg_ack), 64'd0);
            check("t5_core_load", dmem_dataOut, 64'hDEAD_BEEF_0123_4567);
        end
        mem_enable = 1'b0;
        cycle();
        check("t5_idle1_no_ack", 64'(dbg_ack), 64'd0);
        cycle();
        check("t5_ack", 64'(dbg_ack), 64'd1);
        check("t5_rdata", dbg_rdata, 64'hA5A5);
        dbg_req = 1'b0;
        cycle();
        check("t5_rdata_hold", dbg_rdata, 64'hA5A5);
        check("t5_dout_hold", dmem_dataOut, 64'hDEAD_BEEF_0123_4567);
        check("t5_rd", 64'(rd_count), 64'd7);

        // Store counter saturation.
        force dut.wr_count_q = 32'hFFFF_FFFE;
        m_wr = 32'hFFFF_FFFE;
        #1;
        release dut.wr_count_q;
        mem_enable = 1'b1; store_enable = 1'b1; dmem_address = 32'd10;
        dmem_dataIn = 64'h0101_0202_0303_0404;
        cycle();
        check("t6_wr_sat1", 64'(wr_count), 64'hFFFF_FFFF);
        dmem_dataIn = 64'h0505_0606_0707_0808;
        cycle();
        mem_enable = 1'b0;
        check("t6_wr_sat2", 64'(wr_count), 64'hFFFF_FFFF);

        // Randomized core and debug traffic against the model.
        dbg_busy = 1'b0;
        dbg_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            mem_enable   = 1'($urandom_range(0, 1));
            store_enable = 1'($urandom_range(0, 1));
            dmem_address = ($urandom_range(0, 15) == 0) ? 32'(256 + $urandom_range(0, 1000))
                                                        : 32'($urandom_range(0, 255));
            dmem_dataIn  = {$urandom, $urandom};
            if (!dbg_busy && $urandom_range(0, 3) == 0) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = ($urandom_range(0, 15) == 0) ? 32'h0001_0000 : 32'($urandom_range(0, 255));
                dbg_wdata = {$urandom, $urandom};
                dbg_busy  = 1'b1;
                dbg_wait  = 0;
            end
            cycle();
            if (dbg_busy) begin
                dbg_wait++;
                if (m_ph == 2) begin
                    dbg_req  = 1'b0;
                    dbg_busy = 1'b0;
                end else if (dbg_wait > 200) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rand_dbg_timeout: request outstanding %0d cycles", dbg_wait);
                    dbg_req  = 1'b0;
                    dbg_busy = 1'b0;
                end
            end
        end
        mem_enable = 1'b0;
        dbg_req    = 1'b0;
        repeat (2) cycle();

        // Asynchronous reset while a debug read is in progress.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd9;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        dbg_req = 1'b0;
        check("t1_dout", dmem_dataOut, 64'd0);
        check("t1_dbg_rdata", dbg_rdata, 64'd0);
        check("t1_ack", 64'(dbg_ack), 64'd0);
        check("t1_err", 64'(err_oob), 64'd0);
        check("t1_counts", {rd_count, wr_count}, 64'd0);
        check("t1_fsm_idle", 64'(dut.state_q), 64'(dmem_pkg::DBG_IDLE));
        cycle();
        rst = 1'b1;
        repeat (3) begin
            cycle();
            check("t1_no_ack_after", 64'(dbg_ack), 64'd0);
        end
        dbg_op(1'b0, 32'd9, 64'd0);
        check("t1_dbg_after", dbg_rdata, mem_m[9]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
